// File: rtl/min_max_decoder_if.sv
// Bus between a min_max_decoder and its requester: LED bar and start request in, decoded result out.
// The master side drives leds_i/start_i; the slave side (the decoder) drives everything else.
interface min_max_decoder_if #(
    parameter int VALSIZE = 4
);
    logic [2**VALSIZE-1:0] leds_i;
    logic                  start_i;
    logic                  busy_o;
    logic                  valid_o;
    logic [1:0]            com_o;
    logic [VALSIZE-1:0]    min_o;
    logic [VALSIZE-1:0]    max_o;
    logic [VALSIZE-1:0]    value_o;
    logic                  osci_o;
    logic                  error_o;

    modport master (
        output leds_i, start_i,
        input  busy_o, valid_o, com_o, min_o, max_o, value_o, osci_o, error_o
    );

    modport slave (
        input  leds_i, start_i,
        output busy_o, valid_o, com_o, min_o, max_o, value_o, osci_o, error_o
    );
endinterface

// File: rtl/min_max_decoder.sv
// Decodes a min_max_top LED bar from two snapshots WAIT_CYCLES apart; valid_o at start edge +WAIT_CYCLES+2**VALSIZE+1.
// No backpressure: start_i is ignored while busy_o. Optional contiguity checker: define MIN_MAX_DEC_CONTIG_CHECK_EN.
module min_max_decoder #(
    parameter int VALSIZE     = 4,
    parameter int WAIT_CYCLES = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    min_max_decoder_if.slave dec
);
    localparam int LEDS = 2**VALSIZE;
    localparam int CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0]      WAIT_LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [VALSIZE-1:0] IDX_LAST  = '1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SCAN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_busy;

    logic [LEDS-1:0]    r_snap_a;
    logic [LEDS-1:0]    r_snap_b;
    logic [CW-1:0]      r_wait_cnt;
    logic [VALSIZE-1:0] r_idx;
    logic               r_or_found;
    logic               r_and_all;
    logic [VALSIZE-1:0] r_scan_min;
    logic [VALSIZE-1:0] r_scan_max;
    logic [VALSIZE-1:0] r_scan_val;

    logic               r_valid;
    logic [1:0]         r_com;
    logic [VALSIZE-1:0] r_min;
    logic [VALSIZE-1:0] r_max;
    logic [VALSIZE-1:0] r_val;
    logic               r_osci;
    logic               r_error;

    logic               w_or_bit;
    logic               w_and_bit;
    logic               w_osci;
    logic               w_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (dec.start_i) w_next = S_WAIT;
            S_WAIT:  if (r_wait_cnt == WAIT_LAST) w_next = S_SCAN;
            S_SCAN:  if (r_idx == IDX_LAST) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    assign w_or_bit  = r_snap_a[r_idx] | r_snap_b[r_idx];
    assign w_and_bit = r_snap_a[r_idx] & r_snap_b[r_idx];
    assign w_osci    = |(r_snap_a ^ r_snap_b);

`ifdef MIN_MAX_DEC_CONTIG_CHECK_EN
    logic [LEDS-1:0] w_or_vec;
    logic [LEDS-1:0] w_and_vec;

    function automatic logic [LEDS-1:0] range_mask(input logic [VALSIZE-1:0] lo,
                                                   input logic [VALSIZE-1:0] hi);
        logic [LEDS-1:0] m;
        m = '0;
        for (int i = 0; i < LEDS; i++) begin
            m[i] = (i >= int'(lo)) && (i <= int'(hi));
        end
        return m;
    endfunction

    assign w_or_vec  = r_snap_a | r_snap_b;
    assign w_and_vec = r_snap_a & r_snap_b;

    // An all-off bar is a legal pattern; only lit bars are held to the band shape.
    always_comb begin
        w_err = r_or_found &&
                ((w_and_vec == '0) ||
                 (w_and_vec != range_mask(r_scan_min, r_scan_val)) ||
                 (w_or_vec  != range_mask(r_scan_min, r_scan_max)));
    end
`else
    always_comb begin
        w_err = 1'b0;
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_snap_a   <= '0;
            r_snap_b   <= '0;
            r_wait_cnt <= '0;
            r_idx      <= '0;
            r_or_found <= 1'b0;
            r_and_all  <= 1'b0;
            r_scan_min <= '0;
            r_scan_max <= '0;
            r_scan_val <= '0;
            r_valid    <= 1'b0;
            r_com      <= 2'b00;
            r_min      <= '0;
            r_max      <= '0;
            r_val      <= '0;
            r_osci     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (dec.start_i) begin
                        r_snap_a   <= dec.leds_i;
                        r_wait_cnt <= '0;
                        r_idx      <= '0;
                        r_or_found <= 1'b0;
                        r_and_all  <= 1'b1;
                        r_scan_min <= '0;
                        r_scan_max <= '0;
                        r_scan_val <= '0;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        r_snap_b <= dec.leds_i;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_SCAN: begin
                    // Ascending scan: first OR hit is min, last OR/AND hits are max/value.
                    if (w_or_bit && !r_or_found) begin
                        r_scan_min <= r_idx;
                        r_or_found <= 1'b1;
                    end
                    if (w_or_bit)   r_scan_max <= r_idx;
                    if (w_and_bit)  r_scan_val <= r_idx;
                    if (!w_and_bit) r_and_all  <= 1'b0;
                    r_idx <= r_idx + 1'b1;
                end
                S_DONE: begin
                    r_valid <= 1'b1;
                    r_osci  <= w_osci;
                    r_error <= w_err;
                    if (!r_or_found) begin
                        r_com <= 2'b10;
                        r_min <= '0;
                        r_max <= '0;
                        r_val <= '0;
                    end else if (r_and_all) begin
                        r_com <= 2'b11;
                        r_min <= '0;
                        r_max <= '1;
                        r_val <= '1;
                    end else begin
                        r_com <= ((r_scan_min == '0) && !w_osci) ? 2'b01 : 2'b00;
                        r_min <= r_scan_min;
                        r_max <= r_scan_max;
                        r_val <= r_scan_val;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dec.busy_o  = w_busy;
    assign dec.valid_o = r_valid;
    assign dec.com_o   = r_com;
    assign dec.min_o   = r_min;
    assign dec.max_o   = r_max;
    assign dec.value_o = r_val;
    assign dec.osci_o  = r_osci;
    assign dec.error_o = r_error;
endmodule
